regfile_sequencer: RTL and testbench



---
 rtl/regfile_sequencer.sv | 108 ++++++++++
 tb/tb_regfile_sequencer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/regfile_sequencer.sv
// Command sequencer for an 8-entry register file: accepts WRITE/COPY/SWAP/READ
// over valid/ready and drives the register file ports over several cycles.
module regfile_sequencer #(
  parameter int DATA_W = 16,
  parameter int IDX_W  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [IDX_W-1:0]  cmd_rd,
  input  logic [IDX_W-1:0]  cmd_rs,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic [IDX_W-1:0]  rf_writenum,
  output logic              rf_write,
  output logic [IDX_W-1:0]  rf_readnum,
  output logic [DATA_W-1:0] rf_data_in,
  input  logic [DATA_W-1:0] rf_data_out,
  output logic              done,
  output logic [DATA_W-1:0] result
);

  typedef enum logic [2:0] {IDLE, RD1, RD2, WR1, WR2, DONE} state_t;
  typedef enum logic [1:0] {OP_WRITE, OP_COPY, OP_SWAP, OP_READ} op_t;

  state_t state, next_state;
  op_t              op;
  logic [IDX_W-1:0]  rd, rs;
  logic [DATA_W-1:0] imm, tmp_a, tmp_b;

  // Last driven port values, so the rf_* ports hold outside active states.
  logic [IDX_W-1:0]  writenum_q, readnum_q;
  logic [DATA_W-1:0] data_in_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      op         <= OP_WRITE;
      rd         <= '0;
      rs         <= '0;
      imm        <= '0;
      tmp_a      <= '0;
      tmp_b      <= '0;
      writenum_q <= '0;
      readnum_q  <= '0;
      data_in_q  <= '0;
      result     <= '0;
    end else begin
      state      <= next_state;
      writenum_q <= rf_writenum;
      readnum_q  <= rf_readnum;
      data_in_q  <= rf_data_in;
      if (cmd_ready && cmd_valid) begin
        op  <= op_t'(cmd_op);
        rd  <= cmd_rd;
        rs  <= cmd_rs;
        imm <= cmd_imm;
      end
      if (state == RD1) tmp_a <= rf_data_out;
      if (state == RD2) tmp_b <= rf_data_out;
      if (state == DONE && op == OP_READ) result <= tmp_a;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: if (cmd_valid) next_state = (op_t'(cmd_op) == OP_WRITE) ? WR1 : RD1;
      RD1: begin
        if (op == OP_SWAP)      next_state = RD2;
        else if (op == OP_COPY) next_state = WR1;
        else                    next_state = DONE;
      end
      RD2:     next_state = WR1;
      WR1:     next_state = (op == OP_SWAP) ? WR2 : DONE;
      WR2:     next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    rf_write    = 1'b0;
    rf_writenum = writenum_q;
    rf_readnum  = readnum_q;
    rf_data_in  = data_in_q;
    unique case (state)
      RD1: rf_readnum = rs;
      RD2: rf_readnum = rd;
      WR1: begin
        rf_write    = 1'b1;
        rf_writenum = rd;
        rf_data_in  = (op == OP_WRITE) ? imm : tmp_a;
      end
      WR2: begin
        rf_write    = 1'b1;
        rf_writenum = rs;
        rf_data_in  = tmp_b;
      end
      default: ;
    endcase
  end

  assign cmd_ready = (state == IDLE) && !reset;
  assign done      = (state == DONE);

endmodule

// File: tb/tb_regfile_sequencer.sv
// Directed bench for regfile_sequencer driving a behavioural 8x16 register file.
module tb_regfile_sequencer;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_COPY  = 2'b01;
  localparam logic [1:0] OP_SWAP  = 2'b10;
  localparam logic [1:0] OP_READ  = 2'b11;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [2:0]  cmd_rd, cmd_rs;
  logic [15:0] cmd_imm;
  logic [2:0]  rf_writenum, rf_readnum;
  logic        rf_write;
  logic [15:0] rf_data_in, rf_data_out;
  logic        done;
  logic [15:0] result;

  logic [15:0] regs [8];
  int checks = 0;
  int errors = 0;
  int lat, wrc;
  logic [15:0] res_done;

  always #5 clk = ~clk;

  regfile_sequencer #(.DATA_W(16), .IDX_W(3)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rs(cmd_rs), .cmd_imm(cmd_imm),
    .rf_writenum(rf_writenum), .rf_write(rf_write), .rf_readnum(rf_readnum),
    .rf_data_in(rf_data_in), .rf_data_out(rf_data_out), .done(done), .result(result)
  );

  // Register file: clocked write, combinational read, no reset.
  always @(posedge clk) if (rf_write) regs[rf_writenum] <= rf_data_in;
  assign rf_data_out = regs[rf_readnum];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [2:0] rd, input logic [2:0] rs,
                         input logic [15:0] imm, output int l, output int w,
                         output logic [15:0] rdone);
    int waitc = 0;
    while (!cmd_ready && waitc < 20) begin
      @(posedge clk); #1; waitc++;
    end
    check("ready_wait", {31'b0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_rs = rs; cmd_imm = imm;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    l = 1; w = 0;
    while (!done && l < 20) begin
      if (rf_write) w++;
      check("ready_busy", {31'b0, cmd_ready}, 32'd0);
      @(posedge clk); #1; l++;
    end
    check("ready_done", {31'b0, cmd_ready}, 32'd0);
    rdone = result;
    @(posedge clk); #1;
  endtask

  task automatic read_reg(input string tag, input logic [2:0] idx, input logic [15:0] exp);
    int l, w;
    logic [15:0] rdn;
    run_cmd(OP_READ, 3'd0, idx, 16'h0, l, w, rdn);
    check({tag, "_lat"}, l, 32'd2);
    check({tag, "_wr"}, w, 32'd0);
    check(tag, {16'b0, result}, {16'b0, exp});
  endtask

  initial begin
    for (int i = 0; i < 8; i++) regs[i] = 16'h0;
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b0; cmd_rd = 3'd0; cmd_rs = 3'd0; cmd_imm = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_write", {31'b0, rf_write}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_result", {16'b0, result}, 32'd0);
    check("rst_writenum", {29'b0, rf_writenum}, 32'd0);
    check("rst_readnum", {29'b0, rf_readnum}, 32'd0);
    check("rst_data_in", {16'b0, rf_data_in}, 32'd0);
    reset = 1'b0; #1;
    check("rst_ready", {31'b0, cmd_ready}, 32'd1);

    // WRITE then READ
    run_cmd(OP_WRITE, 3'd3, 3'd0, 16'h00A5, lat, wrc, res_done);
    check("wr_lat", lat, 32'd2);
    check("wr_cnt", wrc, 32'd1);
    read_reg("rd_r3", 3'd3, 16'h00A5);

    // SWAP across boundary indices
    run_cmd(OP_WRITE, 3'd0, 3'd0, 16'h1234, lat, wrc, res_done);
    run_cmd(OP_WRITE, 3'd7, 3'd0, 16'hBEEF, lat, wrc, res_done);
    run_cmd(OP_SWAP, 3'd0, 3'd7, 16'h0, lat, wrc, res_done);
    check("swap_lat", lat, 32'd5);
    check("swap_wr", wrc, 32'd2);
    read_reg("swap_r0", 3'd0, 16'hBEEF);
    read_reg("swap_r7", 3'd7, 16'h1234);

    // COPY and self-SWAP
    run_cmd(OP_WRITE, 3'd2, 3'd0, 16'hFFFF, lat, wrc, res_done);
    run_cmd(OP_COPY, 3'd5, 3'd2, 16'h0, lat, wrc, res_done);
    check("copy_lat", lat, 32'd3);
    check("copy_wr", wrc, 32'd1);
    read_reg("copy_r5", 3'd5, 16'hFFFF);
    read_reg("copy_r2", 3'd2, 16'hFFFF);
    run_cmd(OP_SWAP, 3'd2, 3'd2, 16'h0, lat, wrc, res_done);
    check("sswap_lat", lat, 32'd5);
    read_reg("sswap_r2", 3'd2, 16'hFFFF);

    // cmd_valid held high: only IDLE-cycle commands are taken (k=0,3,6,9)
    begin
      int phase = 0;
      for (int k = 0; k < 10; k++) begin
        cmd_valid = 1'b1; cmd_op = OP_WRITE;
        cmd_rd = (k % 2 == 0) ? 3'd4 : 3'd5;
        cmd_imm = 16'h0100 + 16'(k);
        check("hold_ready", {31'b0, cmd_ready}, (phase == 0) ? 32'd1 : 32'd0);
        phase = (phase == 2) ? 0 : phase + 1;
        @(posedge clk); #1;
      end
      cmd_valid = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
    end
    read_reg("hold_r4", 3'd4, 16'h0106);
    read_reg("hold_r5", 3'd5, 16'h0109);

    // Back-to-back READs; result moves only after done
    read_reg("b2b_r3", 3'd3, 16'h00A5);
    run_cmd(OP_READ, 3'd0, 3'd7, 16'h0, lat, wrc, res_done);
    check("b2b_at_done", {16'b0, res_done}, 32'h00A5);
    check("b2b_r7", {16'b0, result}, 32'h1234);
    run_cmd(OP_WRITE, 3'd4, 3'd0, 16'h0000, lat, wrc, res_done);
    check("b2b_hold", {16'b0, result}, 32'h1234);

    // Reset in the second write cycle of SWAP R1<->R6
    run_cmd(OP_WRITE, 3'd1, 3'd0, 16'h0001, lat, wrc, res_done);
    run_cmd(OP_WRITE, 3'd6, 3'd0, 16'h0006, lat, wrc, res_done);
    cmd_valid = 1'b1; cmd_op = OP_SWAP; cmd_rd = 3'd1; cmd_rs = 3'd6; cmd_imm = 16'h0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("abort_pre_wr", {31'b0, rf_write}, 32'd1);
    check("abort_pre_num", {29'b0, rf_writenum}, 32'd6);
    reset = 1'b1; #1;
    check("abort_wr", {31'b0, rf_write}, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    check("abort_result", {16'b0, result}, 32'd0);
    check("abort_writenum", {29'b0, rf_writenum}, 32'd0);
    check("abort_readnum", {29'b0, rf_readnum}, 32'd0);
    check("abort_data_in", {16'b0, rf_data_in}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; #1;
    check("abort_ready", {31'b0, cmd_ready}, 32'd1);
    read_reg("abort_r1", 3'd1, 16'h0006);
    read_reg("abort_r6", 3'd6, 16'h0006);
    run_cmd(OP_WRITE, 3'd6, 3'd0, 16'h7777, lat, wrc, res_done);
    check("post_wr_lat", lat, 32'd2);
    read_reg("post_r6", 3'd6, 16'h7777);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
